// File: rtl/flow_ctrl_pkg.sv
// Shared widths and flow codes for the PC flow controller.
// The flow_ctrl state encoding is kept private to the controller module.
package flow_ctrl_pkg;
   localparam int CPU_WIDTH  = 32;
   localparam int FLOW_WIDTH = 2;

   typedef logic [FLOW_WIDTH-1:0] flow_t;

   localparam flow_t FLOW_WORK    = 2'd0;
   localparam flow_t FLOW_STOP    = 2'd1;
   localparam flow_t FLOW_REFRESH = 2'd2;

   // Interrupt redirects always beat EX-stage jumps.
   function automatic logic [CPU_WIDTH-1:0] sel_target(
      input logic                 int_req,
      input logic [CPU_WIDTH-1:0] int_addr,
      input logic [CPU_WIDTH-1:0] jump_addr
   );
      return int_req ? int_addr : jump_addr;
   endfunction
endpackage

// File: rtl/flow_ctrl_if.sv
// Redirect/stall requests in, PC flow decisions out.
// The pipeline drives the master side; flow_ctrl is the slave.
interface flow_ctrl_if;
   import flow_ctrl_pkg::*;

   logic                  jump_req_i;
   logic [CPU_WIDTH-1:0]  jump_addr_i;
   logic                  int_req_i;
   logic [CPU_WIDTH-1:0]  int_addr_i;
   logic                  hold_req_i;
   logic                  bus_stall_i;
   logic                  jtag_halt_i;
   logic [FLOW_WIDTH-1:0] flow_pc_o;
   logic                  next_pc_four_o;
   logic [CPU_WIDTH-1:0]  next_pc_o;
   logic                  flush_o;
   logic                  redirect_pend_o;

   modport master (
      output jump_req_i, jump_addr_i, int_req_i, int_addr_i,
             hold_req_i, bus_stall_i, jtag_halt_i,
      input  flow_pc_o, next_pc_four_o, next_pc_o, flush_o, redirect_pend_o
   );

   modport slave (
      input  jump_req_i, jump_addr_i, int_req_i, int_addr_i,
             hold_req_i, bus_stall_i, jtag_halt_i,
      output flow_pc_o, next_pc_four_o, next_pc_o, flush_o, redirect_pend_o
   );
endinterface

// File: rtl/flow_ctrl.sv
// PC flow controller: arbitrates halt, interrupt, jump and stall requests and
// buffers a redirect that arrives while the pipeline is frozen.
module flow_ctrl
   import flow_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   flow_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {S_INIT, S_RUN, S_STALL, S_PEND, S_HALT} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [CPU_WIDTH-1:0]  r_buf_addr;
   logic [CPU_WIDTH-1:0]  w_buf_addr_nxt;
   logic                  r_buf_vld;
   logic                  w_buf_vld_nxt;

   logic                  w_stall;
   logic                  w_redir;
   logic                  w_halt;
   logic                  w_as_run;
   logic                  w_as_pend;
   logic [CPU_WIDTH-1:0]  w_target;
   flow_t                 w_flow;
   logic                  w_four;
   logic [CPU_WIDTH-1:0]  w_next_pc;
   logic                  w_flush;

   assign w_stall  = bus.hold_req_i | bus.bus_stall_i;
   assign w_redir  = bus.int_req_i | bus.jump_req_i;
   assign w_halt   = bus.jtag_halt_i;
   assign w_target = sel_target(bus.int_req_i, bus.int_addr_i, bus.jump_addr_i);

   // Leaving HALT is zero-latency: the release cycle already acts as PEND or RUN.
   assign w_as_pend = (r_state == S_PEND) | ((r_state == S_HALT) & ~w_halt & r_buf_vld);
   assign w_as_run  = (r_state == S_RUN) | (r_state == S_STALL) |
                      ((r_state == S_HALT) & ~w_halt & ~r_buf_vld);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_INIT;
         r_buf_addr <= '0;
         r_buf_vld  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_buf_addr <= w_buf_addr_nxt;
         r_buf_vld  <= w_buf_vld_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_buf_addr_nxt = r_buf_addr;
      w_buf_vld_nxt  = r_buf_vld;
      w_flow         = FLOW_STOP;
      w_four         = 1'b1;
      w_next_pc      = '0;
      w_flush        = 1'b0;

      if (r_state == S_INIT) begin
         if (w_halt) begin
            w_state_nxt = S_HALT;
         end else begin
            w_flow      = FLOW_REFRESH;
            w_four      = 1'b0;
            w_flush     = 1'b1;
            w_state_nxt = S_RUN;
         end
      end else if (w_halt) begin
         w_state_nxt = S_HALT;
      end else if (w_as_pend) begin
         if (!w_stall) begin
            w_flow        = FLOW_WORK;
            w_four        = 1'b0;
            w_next_pc     = bus.int_req_i ? bus.int_addr_i : r_buf_addr;
            w_flush       = 1'b1;
            w_buf_vld_nxt = 1'b0;
            w_state_nxt   = S_RUN;
         end else begin
            // Younger jumps were already flushed; only a fresh interrupt replaces the target.
            if (bus.int_req_i) w_buf_addr_nxt = bus.int_addr_i;
            w_state_nxt = S_PEND;
         end
      end else if (w_as_run) begin
         if (w_redir && w_stall) begin
            w_buf_addr_nxt = w_target;
            w_buf_vld_nxt  = 1'b1;
            w_flush        = 1'b1;
            w_state_nxt    = S_PEND;
         end else if (w_redir) begin
            w_flow      = FLOW_WORK;
            w_four      = 1'b0;
            w_next_pc   = w_target;
            w_flush     = 1'b1;
            w_state_nxt = S_RUN;
         end else if (w_stall) begin
            w_state_nxt = S_STALL;
         end else begin
            w_flow      = FLOW_WORK;
            w_state_nxt = S_RUN;
         end
      end
   end

   assign bus.flow_pc_o       = rst ? FLOW_REFRESH : w_flow;
   assign bus.next_pc_four_o  = rst ? 1'b0 : w_four;
   assign bus.next_pc_o       = rst ? '0 : w_next_pc;
   assign bus.flush_o         = rst | w_flush;
   assign bus.redirect_pend_o = ~rst & r_buf_vld & w_buf_vld_nxt;

endmodule
